// File: rtl/axi_lite_regbank_if.sv
// axi_lite_regbank_if: AXI4-Lite bus bundle with master and slave views
interface axi_lite_regbank_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 64
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi_lite_regbank.sv
// axi_lite_regbank: AXI4-Lite slave with read/write control regs and read-only status regs
module axi_lite_regbank #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 64,
    parameter int NUM_RW = 8,
    parameter int NUM_RO = 4,
    parameter logic [DATA_WIDTH-1:0] RST_VAL = '0
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    axi_lite_regbank_if.slave            s_axi,
    output logic [NUM_RW*DATA_WIDTH-1:0] o_ctrl,
    input  logic [NUM_RO*DATA_WIDTH-1:0] i_status,
    output logic [NUM_RW-1:0]            o_wr_pulse
);
    localparam int NB  = DATA_WIDTH / 8;
    localparam int OFF = $clog2(NB);

    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    logic                  rdy_q;
    logic                  aw_held_q, aw_held_d;
    logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic                  w_held_q, w_held_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [NB-1:0]         wstrb_q, wstrb_d;
    logic                  bvalid_q, bvalid_d;
    logic [1:0]            bresp_q, bresp_d;
    logic [NUM_RW-1:0]     pulse_pend_q, pulse_pend_d;
    logic [NUM_RW-1:0]     wr_pulse_q, wr_pulse_d;
    logic [DATA_WIDTH-1:0] ctrl_q [NUM_RW];
    logic [DATA_WIDTH-1:0] ctrl_d [NUM_RW];

    logic                  aw_hs, w_hs, commit, wr_err;
    logic [ADDR_WIDTH-1:0] wr_addr, wr_idx;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [NB-1:0]         wr_strb;

    r_state_t              r_state_q;
    logic                  arready_q, rvalid_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [1:0]            rresp_q;
    logic [ADDR_WIDTH-1:0] rd_idx;
    logic [DATA_WIDTH-1:0] rd_val;
    logic                  rd_err;

    // rdy_q keeps AW/W ready low until the first edge after reset release
    assign s_axi.awready = rdy_q & ~aw_held_q & ~bvalid_q;
    assign s_axi.wready  = rdy_q & ~w_held_q & ~bvalid_q;
    assign s_axi.bvalid  = bvalid_q;
    assign s_axi.bresp   = bresp_q;
    assign s_axi.arready = arready_q;
    assign s_axi.rvalid  = rvalid_q;
    assign s_axi.rdata   = rdata_q;
    assign s_axi.rresp   = rresp_q;
    assign o_wr_pulse    = wr_pulse_q;

    assign aw_hs   = s_axi.awvalid & s_axi.awready;
    assign w_hs    = s_axi.wvalid & s_axi.wready;
    assign wr_addr = aw_held_q ? awaddr_q : s_axi.awaddr;
    assign wr_data = w_held_q ? wdata_q : s_axi.wdata;
    assign wr_strb = w_held_q ? wstrb_q : s_axi.wstrb;
    assign wr_idx  = wr_addr >> OFF;
    assign commit  = (aw_held_q | aw_hs) & (w_held_q | w_hs);
    assign wr_err  = wr_idx >= ADDR_WIDTH'(NUM_RW);

    // Flatten the control registers onto the output bus
    always_comb begin
        o_ctrl = '0;
        for (int i = 0; i < NUM_RW; i++) o_ctrl[i*DATA_WIDTH +: DATA_WIDTH] = ctrl_q[i];
    end

    // Capture AW and W independently, commit once both are present, hold B until accepted
    always_comb begin
        aw_held_d    = aw_held_q | aw_hs;
        awaddr_d     = aw_hs ? s_axi.awaddr : awaddr_q;
        w_held_d     = w_held_q | w_hs;
        wdata_d      = w_hs ? s_axi.wdata : wdata_q;
        wstrb_d      = w_hs ? s_axi.wstrb : wstrb_q;
        bvalid_d     = bvalid_q & ~s_axi.bready;
        bresp_d      = bresp_q;
        pulse_pend_d = '0;
        wr_pulse_d   = pulse_pend_q;
        ctrl_d       = ctrl_q;
        if (commit) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = wr_err ? 2'b10 : 2'b00;
            for (int i = 0; i < NUM_RW; i++) begin
                if (!wr_err && wr_idx == ADDR_WIDTH'(i)) begin
                    pulse_pend_d[i] = 1'b1;
                    for (int j = 0; j < NB; j++)
                        if (wr_strb[j]) ctrl_d[i][j*8 +: 8] = wr_data[j*8 +: 8];
                end
            end
        end
    end

    // Write-path state; reset abandons any half-captured transaction
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rdy_q        <= 1'b0;
            aw_held_q    <= 1'b0;
            awaddr_q     <= '0;
            w_held_q     <= 1'b0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            bvalid_q     <= 1'b0;
            bresp_q      <= 2'b00;
            pulse_pend_q <= '0;
            wr_pulse_q   <= '0;
            ctrl_q       <= '{default: RST_VAL};
        end else begin
            rdy_q        <= 1'b1;
            aw_held_q    <= aw_held_d;
            awaddr_q     <= awaddr_d;
            w_held_q     <= w_held_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            bvalid_q     <= bvalid_d;
            bresp_q      <= bresp_d;
            pulse_pend_q <= pulse_pend_d;
            wr_pulse_q   <= wr_pulse_d;
            ctrl_q       <= ctrl_d;
        end
    end

    // Decode the read address into register value and response
    always_comb begin
        rd_idx = s_axi.araddr >> OFF;
        rd_val = '0;
        rd_err = rd_idx >= ADDR_WIDTH'(NUM_RW + NUM_RO);
        for (int i = 0; i < NUM_RW; i++)
            if (rd_idx == ADDR_WIDTH'(i)) rd_val = ctrl_q[i];
        for (int i = 0; i < NUM_RO; i++)
            if (rd_idx == ADDR_WIDTH'(NUM_RW + i)) rd_val = i_status[i*DATA_WIDTH +: DATA_WIDTH];
    end

    // Read FSM: accept AR in R_IDLE, present data in R_DATA until taken
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= 2'b00;
        end else if (r_state_q == R_IDLE) begin
            if (arready_q && s_axi.arvalid) begin
                r_state_q <= R_DATA;
                arready_q <= 1'b0;
                rvalid_q  <= 1'b1;
                rdata_q   <= rd_val;
                rresp_q   <= rd_err ? 2'b10 : 2'b00;
            end else begin
                arready_q <= 1'b1;
            end
        end else if (s_axi.rready) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b1;
            rvalid_q  <= 1'b0;
        end
    end
endmodule
